// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcodes, ALU ops,
// PC/ALU source selects and the instruction class enum.
package ctrl_pkg;

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpRet   = 6'b000001;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpCall  = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpDiv   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpMul   = 6'b011100;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpHalt  = 6'b111111;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluRtype = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluOr    = 3'b100;

  localparam logic [1:0] PcSeq    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcStack  = 2'b11;

  localparam logic [1:0] AluSrcReg = 2'b00;
  localparam logic [1:0] AluSrcImm = 2'b01;

  typedef enum logic [3:0] {
    ClsRtype,
    ClsImm,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsCall,
    ClsRet,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  function automatic logic is_mem(op_class_e cls);
    return (cls == ClsLoad) || (cls == ClsStore);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class, ALU op/source, destination
// register select and legality.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] op,
  output op_class_e           op_class,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          alu_src,
  output logic                reg_dst,
  output logic                legal
);

  always_comb begin
    op_class = ClsIllegal;
    alu_op   = ALUOP_W'(AluAdd);
    alu_src  = AluSrcReg;
    reg_dst  = 1'b0;
    case (op)
      OPCODE_W'(OpRtype), OPCODE_W'(OpMul), OPCODE_W'(OpDiv): begin
        op_class = ClsRtype;
        alu_op   = ALUOP_W'(AluRtype);
        reg_dst  = 1'b1;
      end
      OPCODE_W'(OpAddi): begin
        op_class = ClsImm;
        alu_src  = AluSrcImm;
      end
      OPCODE_W'(OpAddiu): begin
        op_class = ClsImm;
        alu_op   = ALUOP_W'(AluSub);
        alu_src  = AluSrcImm;
      end
      OPCODE_W'(OpAndi): begin
        op_class = ClsImm;
        alu_op   = ALUOP_W'(AluAnd);
        alu_src  = AluSrcImm;
      end
      OPCODE_W'(OpOri): begin
        op_class = ClsImm;
        alu_op   = ALUOP_W'(AluOr);
        alu_src  = AluSrcImm;
      end
      OPCODE_W'(OpLw): begin
        op_class = ClsLoad;
        alu_src  = AluSrcImm;
      end
      OPCODE_W'(OpSw): begin
        op_class = ClsStore;
        alu_src  = AluSrcImm;
      end
      OPCODE_W'(OpBeq): begin
        op_class = ClsBranch;
        alu_op   = ALUOP_W'(AluSub);
      end
      OPCODE_W'(OpJ):    op_class = ClsJump;
      OPCODE_W'(OpCall): op_class = ClsCall;
      OPCODE_W'(OpRet):  op_class = ClsRet;
      OPCODE_W'(OpHalt): op_class = ClsHalt;
      default: ;
    endcase
  end

  assign legal = (op_class != ClsIllegal);

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle CPU control FSM with memory-wait timeout. Define CTRL_PERF_EN to add
// the retired_cnt / cycle_cnt performance counters.
module mcycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ack,
  output logic [2:0]          stage,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                push,
  output logic                pop,
  output logic                branch,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                halted,
  output logic                err_timeout,
`ifdef CTRL_PERF_EN
  output logic [31:0]         retired_cnt,
  output logic [31:0]         cycle_cnt,
`endif
  output logic                illegal
);

  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [7:0]          wait_q, wait_d;
  logic                err_q, err_d;
  logic [2:0]          st;
  logic [OPCODE_W-1:0] dec_op;
  op_class_e           dec_class;
  logic [ALUOP_W-1:0]  dec_alu_op;
  logic [1:0]          dec_alu_src;
  logic                dec_reg_dst;
  logic                dec_legal;
  logic                timeout;

  // op_q is only written at the end of DECODE, so DECODE itself decodes the live opcode.
  assign dec_op = (state_q == StDecode) ? opcode : op_q;

  ctrl_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .op       (dec_op),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .alu_src  (dec_alu_src),
    .reg_dst  (dec_reg_dst),
    .legal    (dec_legal)
  );

  // Ack in the same cycle the counter would expire takes priority.
  assign timeout = !mem_ack && (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ack) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end
      end
      StDecode: begin
        op_d = opcode;
        if (!dec_legal) begin
          state_d = StFetch;
        end else begin
          case (dec_class)
            ClsJump, ClsCall, ClsRet: state_d = StFetch;
            ClsHalt:                  state_d = StHalt;
            default:                  state_d = StExec;
          endcase
        end
      end
      StExec: begin
        if (dec_class == ClsBranch) state_d = StFetch;
        else if (is_mem(dec_class)) state_d = StMem;
        else                        state_d = StWb;
      end
      StMem: begin
        if (mem_ack) begin
          state_d = (dec_class == ClsLoad) ? StWb : StFetch;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if ((state_q == StFetch || state_q == StMem) && !mem_ack) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= '0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // While reset is held the outputs present the FETCH decode, not the stale state.
  assign st          = reset ? StFetch : state_q;
  assign err_timeout = err_q & ~reset;

  always_comb begin
    stage      = st;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    branch     = 1'b0;
    pc_src     = PcSeq;
    alu_src    = AluSrcReg;
    alu_op     = '0;
    halted     = 1'b0;
    illegal    = 1'b0;
    unique case (st)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ack && !reset) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PcSeq;
        end
      end
      StDecode: begin
        illegal = !dec_legal;
        case (dec_class)
          ClsJump: begin
            pc_write = 1'b1;
            pc_src   = PcJump;
          end
          ClsCall: begin
            pc_write = 1'b1;
            pc_src   = PcJump;
            push     = 1'b1;
          end
          ClsRet: begin
            pc_write = 1'b1;
            pc_src   = PcStack;
            pop      = 1'b1;
          end
          default: ;
        endcase
      end
      StExec: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        if (dec_class == ClsBranch) begin
          branch = 1'b1;
          pc_src = PcBranch;
        end
      end
      StMem: begin
        mem_read  = (dec_class == ClsLoad);
        mem_write = (dec_class == ClsStore);
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = dec_reg_dst;
        mem_to_reg = (dec_class == ClsLoad);
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] cycle_q;
  logic        retire;

  assign retire = (state_q inside {StDecode, StExec, StMem, StWb}) && (state_d == StFetch);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
      cycle_q   <= 32'd0;
    end else begin
      if (state_q != StHalt) cycle_q <= cycle_q + 32'd1;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl (WAIT_MAX=4): per-cycle stage and strobe vectors
// with hand-computed expectations.
module tb_mcycle_ctrl;

  localparam logic [5:0] RTYPE = 6'b000000, RET = 6'b000001, J = 6'b000010;
  localparam logic [5:0] CALL = 6'b000011, BEQ = 6'b000100, DIV = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, MUL = 6'b011100, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, HLTOP = 6'b111111, BADOP = 6'b111110;

  // Bit weights of the packed observation word.
  localparam logic [19:0] PCW = 20'h80000, IRW = 20'h40000, RDST = 20'h20000;
  localparam logic [19:0] RWR = 20'h10000, MRD = 20'h08000, MWR = 20'h04000;
  localparam logic [19:0] M2R = 20'h02000, PSH = 20'h01000, POP = 20'h00800;
  localparam logic [19:0] BR = 20'h00400, PC_BR = 20'h00100, PC_J = 20'h00200;
  localparam logic [19:0] PC_STK = 20'h00300, AS_IMM = 20'h00040;
  localparam logic [19:0] AO_SUB = 20'h00008, AO_R = 20'h00010, AO_AND = 20'h00018;
  localparam logic [19:0] AO_OR = 20'h00020, HLT = 20'h00004, ERR = 20'h00002;
  localparam logic [19:0] ILL = 20'h00001;
  localparam logic [19:0] FETCH_ACK = MRD | IRW | PCW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ack = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [2:0] stage;
  logic       pc_write, ir_write, reg_dst, reg_write, mem_read, mem_write;
  logic       mem_to_reg, push, pop, branch, halted, err_timeout, illegal;
  logic [1:0] pc_src, alu_src;
  logic [2:0] alu_op;
`ifdef CTRL_PERF_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif
  logic [19:0] obs;
  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mcycle_ctrl #(
    .OPCODE_W (6),
    .ALUOP_W  (3),
    .WAIT_MAX (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ack     (mem_ack),
    .stage       (stage),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .push        (push),
    .pop         (pop),
    .branch      (branch),
    .pc_src      (pc_src),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .halted      (halted),
    .err_timeout (err_timeout),
`ifdef CTRL_PERF_EN
    .retired_cnt (retired_cnt),
    .cycle_cnt   (cycle_cnt),
`endif
    .illegal     (illegal)
  );

  assign obs = {pc_write, ir_write, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
                push, pop, branch, pc_src, alu_src, alu_op, halted, err_timeout, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, then compare stage and strobes.
  task automatic cyc(input string tag, input logic rst, input logic ack, input logic [5:0] op,
                     input logic [2:0] est, input logic [19:0] eout);
    @(posedge clk);
    #1;
    reset = rst;
    mem_ack = ack;
    opcode = op;
    #1;
    check({tag, ".stage"}, 32'(stage), 32'(est));
    check({tag, ".out"}, 32'(obs), 32'(eout));
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [19:0] edec);
    cyc({tag, ".f"}, 1'b0, 1'b1, op, 3'd0, FETCH_ACK);
    cyc({tag, ".d"}, 1'b0, 1'b0, op, 3'd1, edec);
  endtask

  task automatic alu_instr(input string tag, input logic [5:0] op, input logic [19:0] eex,
                           input logic [19:0] ewb);
    fetch_decode(tag, op, 20'h0);
    cyc({tag, ".e"}, 1'b0, 1'b0, op, 3'd2, eex);
    cyc({tag, ".w"}, 1'b0, 1'b0, op, 3'd4, ewb);
  endtask

  initial begin
    cyc("rst0", 1'b1, 1'b0, 6'd0, 3'd0, MRD);
    cyc("rst_ack", 1'b1, 1'b1, ADDI, 3'd0, MRD);

    alu_instr("addi", ADDI, AS_IMM, RWR);
    alu_instr("rtype", RTYPE, AO_R, RWR | RDST);
    alu_instr("mul", MUL, AO_R, RWR | RDST);
    alu_instr("div", DIV, AO_R, RWR | RDST);
    alu_instr("addiu", ADDIU, AO_SUB | AS_IMM, RWR);
    alu_instr("andi", ANDI, AO_AND | AS_IMM, RWR);
    alu_instr("ori", ORI, AO_OR | AS_IMM, RWR);

    // LW with three stalled MEM cycles; the counter sits at WAIT_MAX-1 when ack arrives.
    fetch_decode("lw", LW, 20'h0);
    cyc("lw.e", 1'b0, 1'b0, LW, 3'd2, AS_IMM);
    cyc("lw.m1", 1'b0, 1'b0, LW, 3'd3, MRD);
    cyc("lw.m2", 1'b0, 1'b0, LW, 3'd3, MRD);
    cyc("lw.m3", 1'b0, 1'b0, LW, 3'd3, MRD);
    cyc("lw.m4", 1'b0, 1'b1, LW, 3'd3, MRD);
    cyc("lw.w", 1'b0, 1'b0, LW, 3'd4, RWR | M2R);

    fetch_decode("sw", SW, 20'h0);
    cyc("sw.e", 1'b0, 1'b0, SW, 3'd2, AS_IMM);
    cyc("sw.m", 1'b0, 1'b1, SW, 3'd3, MWR);

    fetch_decode("beq", BEQ, 20'h0);
    cyc("beq.e", 1'b0, 1'b0, BEQ, 3'd2, AO_SUB | BR | PC_BR);

    fetch_decode("call", CALL, PCW | PC_J | PSH);
    fetch_decode("ret", RET, PCW | PC_STK | POP);
    fetch_decode("j", J, PCW | PC_J);
    fetch_decode("bad", BADOP, ILL);

    // Ack on the fourth waiting FETCH cycle still decodes normally.
    cyc("wt.1", 1'b0, 1'b0, J, 3'd0, MRD);
    cyc("wt.2", 1'b0, 1'b0, J, 3'd0, MRD);
    cyc("wt.3", 1'b0, 1'b0, J, 3'd0, MRD);
    cyc("wt.4", 1'b0, 1'b1, J, 3'd0, FETCH_ACK);
    cyc("wt.d", 1'b0, 1'b0, J, 3'd1, PCW | PC_J);

    // Four FETCH cycles with no ack time out into HALT.
    cyc("to.1", 1'b0, 1'b0, J, 3'd0, MRD);
    cyc("to.2", 1'b0, 1'b0, J, 3'd0, MRD);
    cyc("to.3", 1'b0, 1'b0, J, 3'd0, MRD);
    cyc("to.4", 1'b0, 1'b0, J, 3'd0, MRD);
    cyc("to.halt", 1'b0, 1'b0, J, 3'd5, HLT | ERR);
    cyc("to.hold", 1'b0, 1'b1, J, 3'd5, HLT | ERR);
    cyc("to.rst", 1'b1, 1'b0, J, 3'd0, MRD);
    cyc("to.clr", 1'b0, 1'b0, J, 3'd0, MRD);

    // Halt opcode stays halted until reset.
    cyc("h.f", 1'b0, 1'b1, HLTOP, 3'd0, FETCH_ACK);
    cyc("h.d", 1'b0, 1'b0, HLTOP, 3'd1, 20'h0);
    cyc("h.1", 1'b0, 1'b0, HLTOP, 3'd5, HLT);
    cyc("h.2", 1'b0, 1'b1, ADDI, 3'd5, HLT);
    cyc("h.rst", 1'b1, 1'b0, ADDI, 3'd0, MRD);

    // Reset in the middle of a stalled MEM.
    fetch_decode("mr", LW, 20'h0);
    cyc("mr.e", 1'b0, 1'b0, LW, 3'd2, AS_IMM);
    cyc("mr.m", 1'b0, 1'b0, LW, 3'd3, MRD);
    cyc("mr.rst", 1'b1, 1'b1, LW, 3'd0, MRD);
    cyc("mr.after", 1'b0, 1'b0, LW, 3'd0, MRD);

`ifdef CTRL_PERF_EN
    cyc("pf.rst", 1'b1, 1'b0, ADDI, 3'd0, MRD);
    alu_instr("pf.a1", ADDI, AS_IMM, RWR);
    alu_instr("pf.a2", ADDI, AS_IMM, RWR);
    alu_instr("pf.a3", ADDI, AS_IMM, RWR);
    fetch_decode("pf.h", HLTOP, 20'h0);
    cyc("pf.halt", 1'b0, 1'b0, HLTOP, 3'd5, HLT);
    check("pf.retired", retired_cnt, 32'd3);
    check("pf.cycles", cycle_cnt, 32'd14);
    cyc("pf.hold", 1'b0, 1'b0, HLTOP, 3'd5, HLT);
    check("pf.frozen", cycle_cnt, 32'd14);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6: opcode field width.
REQ-002 SHALL have parameter ALUOP_W, default 3: alu_op width.
REQ-003 SHALL have parameter WAIT_MAX, default 15: max memory-wait cycles before timeout; range 1..255.
REQ-004 SHALL have port clk  in  1: clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port opcode  in  OPCODE_W: instruction opcode from the IR.
REQ-007 SHALL have port mem_ack  in  1: memory transfer complete this cycle.
REQ-008 SHALL have port stage  out  3: current state encoding.
REQ-009 SHALL have outputs pc_write, ir_write, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, push, pop, branch  out  1 each: datapath strobes.
REQ-010 SHALL have outputs pc_src  out  2 (00 PC+4, 01 branch, 10 jump, 11 stack) and alu_src  out  2 (00 reg, 01 imm).
REQ-011 SHALL have output alu_op  out  ALUOP_W: 000 add, 001 sub, 010 R-type, 011 and, 100 or.
REQ-012 SHALL have outputs halted, err_timeout, illegal  out  1 each: status.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; outputs decoded from state and latched opcode op_q.
REQ-014 FETCH: mem_read=1; on mem_ack: ir_write=1, pc_write=1, pc_src=00, next DECODE; else stay.
REQ-015 DECODE: op_q <= opcode; one cycle; op_q used in all later states.
REQ-016 DECODE, J (000010): pc_write=1, pc_src=10 -> FETCH; CALL (000011): also push=1; RET (000001): pop=1, pc_write=1, pc_src=11 -> FETCH.
REQ-017 DECODE, HALT opcode (111111) -> HALT; unlisted opcode -> illegal pulses 1 cycle -> FETCH.
REQ-018 DECODE, R-type (000000), MUL (011100), DIV (000101), ADDI (001000), ADDIU (001001), ANDI (001100), ORI (001101), LW (100011), SW (101011), BEQ (000100) -> EXEC.
REQ-019 EXEC: alu_op/alu_src per class (R-type/MUL/DIV 010/00; ADDI, LW, SW 000/01; ADDIU 001/01; ANDI 011/01; ORI 100/01; BEQ 001/00); BEQ also branch=1, pc_src=01 -> FETCH.
REQ-020 EXEC next: LW, SW -> MEM; others -> WB.
REQ-021 MEM: LW mem_read=1, SW mem_write=1; held until mem_ack; then LW -> WB, SW -> FETCH.
REQ-022 WB: reg_write=1; reg_dst=1 for R-type/MUL/DIV else 0; mem_to_reg=1 for LW; -> FETCH.
REQ-023 Wait counter (8 bit) counts consecutive FETCH/MEM cycles with mem_ack=0, clears on state change; reaching WAIT_MAX -> HALT, err_timeout set sticky.
REQ-024 mem_ack=1 in the cycle the counter reaches WAIT_MAX: ack wins, normal transition, no error.
REQ-025 HALT: halted=1, all strobes 0; exit only via reset.
REQ-026 Strobes not named for a state SHALL be 0 in that state; no latches.

Reset
REQ-027 reset SHALL force state FETCH, op_q=0, wait counter 0, err_timeout=0, illegal=0; reset wins over all events, including mid-MEM.
REQ-028 Outputs during/after reset SHALL be the FETCH decode: mem_read=1, stage=0, all other outputs 0.

Configuration
REQ-029 With CTRL_PERF_EN defined SHALL add outputs retired_cnt and cycle_cnt (32 bit each, reset 0, wrap at 2^32-1 to 0).
REQ-030 cycle_cnt SHALL increment every non-HALT cycle; retired_cnt on every transition into FETCH from DECODE/EXEC/MEM/WB (illegal included).
REQ-031 Without CTRL_PERF_EN the ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package ctrl_pkg SHALL hold the state enum, opcode constants, alu_op constants, and pc_src/alu_src encodings.
REQ-033 Combinational sub-module ctrl_decode SHALL map op_q to class, alu_op, alu_src, reg_dst, legality.

Verification
REQ-034 ADDI, mem_ack=1 in first FETCH cycle -> states 0,1,2,4,0; alu_op=000, alu_src=01 in EXEC; reg_write=1 in WB.
REQ-035 LW, mem_ack held low 3 MEM cycles -> MEM lasts 4 cycles, then WB with mem_to_reg=1, reg_write=1.
REQ-036 WAIT_MAX=4, mem_ack=0 in FETCH -> HALT after 4 cycles, err_timeout=1, halted=1; ack in 4th cycle instead -> DECODE, no error.
REQ-037 CALL then RET -> push=1, pc_src=10 in CALL DECODE; pop=1, pc_src=11 in RET DECODE; each 2 cycles.
REQ-038 Opcode 111110 -> illegal=1 one cycle, back to FETCH; opcode 111111 -> HALT until reset; reset asserted in MEM -> FETCH next cycle.
REQ-039 CTRL_PERF_EN: 3 ADDI then HALT -> retired_cnt=3; cycle_cnt frozen in HALT.
